// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared types and round-robin pick helper for polar_arbiter
package polar_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREQ_DEF  = 4;
  // rr_pick works on a fixed 32-wide request vector; unused upper bits stay zero
  localparam int IDX_W     = 5;
  localparam int MAX_REQ   = 1 << IDX_W;

  typedef logic [2*WIDTH_DEF-1:0]      sample_t;
  typedef logic [$clog2(NREQ_DEF)-1:0] tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t r;
    int    k;
    r = '0;
    for (int o = 0; o < MAX_REQ; o++) begin
      k = (int'(ptr) + o) % n;
      if (o < n && !r.found && req[k[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - requester-tag FIFO tracking samples in flight through the core
module tag_fifo #(
  parameter int TAGS = 32,
  parameter int TW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [TW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(TAGS);

  logic [TW-1:0] mem [TAGS];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // extra pointer MSB distinguishes full from empty when the index bits match
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/polar_arbiter.sv
// rtl/polar_arbiter.sv - round-robin share of one CORDIC core among NREQ I/Q requesters
module polar_arbiter
  import polar_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int TAGS  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         s_valid,
  output logic [NREQ-1:0]         s_ready,
  input  logic [NREQ*2*WIDTH-1:0] s_data,
  output logic [NREQ-1:0]         m_valid,
  input  logic [NREQ-1:0]         m_ready,
  output logic [NREQ*2*WIDTH-1:0] m_data,
  output logic                    c_reset,
  output logic                    c_s_valid,
  input  logic                    c_s_ready,
  output logic [2*WIDTH-1:0]      c_s_data,
  input  logic                    c_m_valid,
  output logic                    c_m_ready,
  input  logic [2*WIDTH-1:0]      c_m_data,
  output logic                    busy,
  output logic                    error
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]         rst_sr;
  logic [TW-1:0]      ptr;
  logic [TW-1:0]      head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  // core reset held for two clocks after reset_n releases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sr <= 2'b11;
    else          rst_sr <= {rst_sr[0], 1'b0};
  end
  assign c_reset = rst_sr[1];

  assign req_ext   = MAX_REQ'(s_valid);
  assign pick      = rr_pick(req_ext, IDX_W'(ptr), NREQ);
  assign c_s_valid = pick.found && !full && !c_reset;
  assign push      = c_s_valid && c_s_ready;

  always_comb begin
    c_s_data = '0;
    s_ready  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick.idx == IDX_W'(k)) begin
        c_s_data   = s_data[k*2*WIDTH +: 2*WIDTH];
        s_ready[k] = push;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= (pick.idx == IDX_W'(NREQ-1)) ? '0 : TW'(pick.idx + 1'b1);
    end
  end

  tag_fifo #(
    .TAGS (TAGS),
    .TW   (TW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (push),
    .push_tag (pick.idx[TW-1:0]),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // with nothing in flight, results are orphans and are drained unconditionally
  assign c_m_ready = c_reset ? 1'b0 : (!empty ? m_ready[head] : 1'b1);
  assign pop       = c_m_valid && c_m_ready && !empty;

  always_comb begin
    m_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      m_valid[k] = c_m_valid && !empty && !c_reset && (head == TW'(k));
    end
  end

  assign m_data = {NREQ{c_m_data}};
  assign busy   = !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (c_m_valid && empty && !c_reset) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_polar_arbiter.sv
// tb/tb_polar_arbiter.sv - randomized bench for polar_arbiter with queue-based reference
module tb_polar_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int T   = 4;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     s_valid, s_ready, m_valid, m_ready;
  logic [N*2*W-1:0] s_data, m_data;
  logic             c_reset, c_s_valid, c_s_ready, c_m_valid, c_m_ready, busy, error;
  logic [2*W-1:0]   c_s_data, c_m_data;

  always #5 clk = ~clk;

  polar_arbiter #(.WIDTH(W), .NREQ(N), .TAGS(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .c_reset(c_reset), .c_s_valid(c_s_valid), .c_s_ready(c_s_ready), .c_s_data(c_s_data),
    .c_m_valid(c_m_valid), .c_m_ready(c_m_ready), .c_m_data(c_m_data),
    .busy(busy), .error(error)
  );

  typedef struct { logic [31:0] d; int t; } core_e;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ptr_m;
  int          tagq[$];
  logic [31:0] expq[N][$];
  core_e       coreq[$];
  bit          err_m;
  int          creset_cnt;
  bit          rv[N];
  logic [31:0] rd[N];
  int          v_rate[N], r_rate[N];
  bit          core_in_en, core_ret_en, orphan_inj, rst_req;
  int          ret_budget;
  int          acc_cnt[N];
  int          total_acc, total_del, rr_breaks, last_grant, first_grant, stall_cnt;
  int          deliv_order[$];
  logic [31:0] last_deliv[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stand-in for the CORDIC: exact magnitude and phase scaled so pi = 2^15
  function automatic logic [31:0] polar_of(input logic [31:0] d);
    real i, q, mag, ph;
    int  mi, pc;
    i   = real'($signed(d[15:0]));
    q   = real'($signed(d[31:16]));
    mag = $sqrt(i*i + q*q);
    ph  = $atan2(q, i) * 32768.0 / 3.14159265358979;
    mi  = int'(mag);
    pc  = int'(ph);
    return {mi[15:0], pc[15:0]};
  endfunction

  task automatic model_reset();
    tagq.delete();
    for (int k = 0; k < N; k++) expq[k].delete();
    coreq.delete();
    ptr_m = 0; err_m = 0; creset_cnt = 2; last_grant = -1;
  endtask

  function automatic bit pending();
    bit p;
    p = (tagq.size() > 0);
    for (int k = 0; k < N; k++) p = p | rv[k];
    return p;
  endfunction

  task automatic step();
    bit          creset_m, full_m, csv_m, ret_v, cmr_m, pop_m, err_set;
    int          win, head_m;
    logic [N-1:0] sv, mr, sr_exp, mv_exp;
    logic [31:0] d;
    reset_n = !rst_req;
    if (rst_req) model_reset();
    creset_m = rst_req || (creset_cnt > 0);
    if (creset_m) coreq.delete();
    for (int k = 0; k < N; k++) begin
      if (!rv[k] && $urandom_range(99) < v_rate[k]) begin
        rv[k] = 1'b1;
        rd[k] = $urandom;
      end
      sv[k] = rv[k];
      s_data[k*2*W +: 2*W] = rd[k];
      mr[k] = ($urandom_range(99) < r_rate[k]);
    end
    s_valid   = sv;
    m_ready   = mr;
    c_s_ready = core_in_en && (coreq.size() < 8) && !creset_m;
    ret_v     = !creset_m && coreq.size() > 0 && core_ret_en && ret_budget != 0;
    if (ret_v) ret_v = (coreq[0].t <= cyc);
    c_m_valid = ret_v || orphan_inj;
    c_m_data  = ret_v ? polar_of(coreq[0].d) : $urandom;
    #4;
    full_m = (tagq.size() >= T);
    csv_m  = (sv != 0) && !full_m && !creset_m;
    win = -1;
    for (int o = 0; o < N; o++) if (win < 0 && sv[(ptr_m + o) % N]) win = (ptr_m + o) % N;
    sr_exp = (csv_m && c_s_ready) ? (N'(1) << win) : '0;
    head_m = (tagq.size() > 0) ? tagq[0] : -1;
    cmr_m  = creset_m ? 1'b0 : ((head_m >= 0) ? mr[head_m] : 1'b1);
    mv_exp = (c_m_valid && head_m >= 0 && !creset_m) ? (N'(1) << head_m) : '0;
    pop_m  = c_m_valid && cmr_m && (head_m >= 0);
    err_set = c_m_valid && (head_m < 0) && !creset_m;
    chk("c_reset", c_reset, creset_m);
    chk("c_s_valid", c_s_valid, csv_m);
    chk("s_ready", s_ready, sr_exp);
    chk("c_m_ready", c_m_ready, cmr_m);
    chk("m_valid", m_valid, mv_exp);
    chk("busy", busy, tagq.size() > 0);
    chk("error", error, err_m);
    if (csv_m) chk("c_s_data", c_s_data, rd[win]);
    if (c_m_valid && head_m == 2 && !mr[2]) stall_cnt++;
    for (int k = 0; k < N; k++) begin
      if (mv_exp[k] && mr[k]) begin
        d = m_data[k*2*W +: 2*W];
        if (expq[k].size() == 0) chk("unexpected_result", 1'b1, 1'b0);
        else chk("m_data", d, expq[k].pop_front());
        deliv_order.push_back(k);
        last_deliv[k] = d;
        total_del++;
      end
    end
    @(posedge clk);
    if (!rst_req) begin
      if (creset_cnt > 0) creset_cnt--;
      if (csv_m && c_s_ready) begin
        tagq.push_back(win);
        expq[win].push_back(polar_of(rd[win]));
        coreq.push_back('{rd[win], cyc + LAT});
        rv[win] = 1'b0;
        acc_cnt[win]++;
        total_acc++;
        ptr_m = (win + 1) % N;
        if (last_grant < 0) first_grant = win;
        else if (win != (last_grant + 1) % N) rr_breaks++;
        last_grant = win;
      end
      if (ret_v && cmr_m) begin
        void'(coreq.pop_front());
        if (ret_budget > 0) ret_budget--;
      end
      if (pop_m) void'(tagq.pop_front());
      if (err_set) err_m = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_rates(input int v, input int r);
    for (int k = 0; k < N; k++) begin v_rate[k] = v; r_rate[k] = r; end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    set_rates(0, 100);
    core_ret_en = 1'b1; ret_budget = -1;
    while (pending() && n < 200) begin step(); n++; end
    chk({tag, "_drain_done"}, n < 200, 1'b1);
    for (int k = 0; k < N; k++) chk({tag, "_queue_empty"}, expq[k].size(), 0);
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) acc_cnt[k] = 0;
    total_acc = 0; total_del = 0; rr_breaks = 0; last_grant = -1; first_grant = -1;
    stall_cnt = 0; deliv_order.delete();
  endtask

  initial begin
    set_rates(0, 100);
    for (int k = 0; k < N; k++) begin rv[k] = 1'b0; rd[k] = '0; end
    core_in_en = 1'b1; core_ret_en = 1'b1; ret_budget = -1; orphan_inj = 1'b0;
    rst_req = 1'b1; reset_n = 1'b0;
    s_valid = '0; s_data = '0; m_ready = '0; c_s_ready = 1'b0; c_m_valid = 1'b0; c_m_data = '0;
    model_reset();
    clear_stats();
    @(negedge clk);

    // reset state and c_reset stretch
    repeat (3) step();
    rst_req = 1'b0;
    repeat (3) step();

    // fairness: everyone always valid
    clear_stats();
    set_rates(100, 100);
    for (int c = 0; c < 600 && total_acc < 400; c++) step();
    chk("fair_total", total_acc, 400);
    chk("fair_first", first_grant, 0);
    chk("fair_rr_breaks", rr_breaks, 0);
    for (int k = 0; k < N; k++) chk("fair_share", acc_cnt[k], 100);
    drain("fair");

    // routing of known vectors
    clear_stats();
    rv[1] = 1'b1; rd[1] = {16'd0, 16'd1000};
    step();
    rv[3] = 1'b1; rd[3] = {16'd1000, 16'd0};
    drain("route");
    chk("route_count", deliv_order.size(), 2);
    if (deliv_order.size() == 2) begin
      chk("route_order0", deliv_order[0], 1);
      chk("route_order1", deliv_order[1], 3);
    end
    chk("route_req1", last_deliv[1], 32'h03E8_0000);
    chk("route_req3", last_deliv[3], 32'h03E8_4000);

    // head-of-line backpressure on requester 2
    clear_stats();
    set_rates(60, 100);
    r_rate[2] = 0;
    rv[2] = 1'b1; rd[2] = $urandom;
    repeat (50) step();
    chk("bp_stalled", stall_cnt > 30, 1'b1);
    drain("bp");
    chk("bp_all_delivered", total_del, total_acc);

    // randomized mixed traffic
    clear_stats();
    for (int k = 0; k < N; k++) begin
      v_rate[k] = $urandom_range(20, 90);
      r_rate[k] = $urandom_range(30, 100);
    end
    repeat (300) step();
    drain("rand");
    chk("rand_all_delivered", total_del, total_acc);

    // full: core never returns
    clear_stats();
    core_ret_en = 1'b0;
    set_rates(100, 100);
    repeat (20) step();
    chk("full_accepts", total_acc, T);
    ret_budget = 1; core_ret_en = 1'b1;
    repeat (10) step();
    chk("full_one_more", total_acc, T + 1);
    drain("full");

    // orphan result with empty FIFO
    orphan_inj = 1'b1;
    step();
    orphan_inj = 1'b0;
    repeat (3) step();
    chk("orphan_sticky", error, 1'b1);

    // reset in the middle of traffic
    clear_stats();
    set_rates(70, 80);
    repeat (30) step();
    rst_req = 1'b1;
    repeat (2) step();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_error", error, 1'b0);
    chk("midrst_s_ready", s_ready, '0);
    rst_req = 1'b0;
    clear_stats();
    repeat (30) step();
    drain("midrst");
    chk("midrst_all_delivered", total_del, total_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
